// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: arbiter state encoding, memory function codes and port sizing constants
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif
package mem_arb_pkg;
  localparam int MAX_PORTS = 8;
  localparam int IDX_W = $clog2(MAX_PORTS);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} arb_state_e;
  typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2} mem_func_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side handshake plus memory_unit-side command bus
interface mem_arbiter_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W = `MEMORY_ADDR_WIDTH,
  parameter int DATA_W = `MEMORY_DATA_WIDTH,
  parameter int FUNC_W = 2
);
  logic [NUM_PORTS-1:0] req_execute, req_lock, grant, done;
  logic [NUM_PORTS*FUNC_W-1:0] req_func;
  logic [NUM_PORTS*ADDR_W-1:0] req_address;
  logic [NUM_PORTS*DATA_W-1:0] req_write_data;
  logic [DATA_W-1:0] read_data, mem_read_data, mem_write_data;
  logic [FUNC_W-1:0] mem_func;
  logic [ADDR_W-1:0] mem_address;
  logic mem_execute, mem_ready;
  modport slave (
    input req_execute, req_func, req_address, req_write_data, req_lock, mem_ready, mem_read_data,
    output grant, done, read_data, mem_execute, mem_func, mem_address, mem_write_data
  );
  modport master (
    output req_execute, req_func, req_address, req_write_data, req_lock, mem_ready, mem_read_data,
    input grant, done, read_data, mem_execute, mem_func, mem_address, mem_write_data
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder; the first requester after last (mod N) wins.
module rr_pick import mem_arb_pkg::*; #(
    parameter int N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx
);
    logic [2*N-1:0] dbl;
    logic [N-1:0] rot;
    int base;
    always_comb begin
        base = (int'(last) + 1) % N;
        dbl = {req, req} >> base;
        rot = dbl[N-1:0];
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) win_idx = IDX_W'((base + i) % N);
        win = (|req) ? N'(1) << win_idx : '0;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-port front end for memory_unit, one transaction at a time
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W = `MEMORY_ADDR_WIDTH,
  parameter int DATA_W = `MEMORY_DATA_WIDTH,
  parameter int FUNC_W = 2
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  arb_state_e state;
  logic [IDX_W-1:0] last, owner, win_idx;
  logic [NUM_PORTS-1:0] elig, win;
`ifdef MEM_ARB_LOCK_EN
  logic locked;
  logic [NUM_PORTS-1:0] lock_oh;
  logic hold;
  assign hold = locked && |(bus.req_lock & lock_oh);
  assign elig = hold ? bus.req_execute & lock_oh : bus.req_execute;
`else
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
  assign elig = bus.req_execute;
`endif
  rr_pick #(.N(NUM_PORTS)) u_pick (.req(elig), .last(last), .win(win), .win_idx(win_idx));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= IDX_W'(NUM_PORTS - 1);
      owner <= '0;
      bus.grant <= '0;
      bus.done <= '0;
      bus.read_data <= '0;
      bus.mem_execute <= 1'b0;
      bus.mem_func <= '0;
      bus.mem_address <= '0;
      bus.mem_write_data <= '0;
`ifdef MEM_ARB_LOCK_EN
      locked <= 1'b0;
      lock_oh <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.mem_ready && |elig) begin
          state <= ISSUE;
          owner <= win_idx;
          bus.grant <= win;
          bus.mem_execute <= 1'b1;
          bus.mem_func <= bus.req_func[int'(win_idx)*FUNC_W +: FUNC_W];
          bus.mem_address <= bus.req_address[int'(win_idx)*ADDR_W +: ADDR_W];
          bus.mem_write_data <= bus.req_write_data[int'(win_idx)*DATA_W +: DATA_W];
        end
        ISSUE: if (!bus.mem_ready) begin
          state <= BUSY;
          bus.mem_execute <= 1'b0;
        end
        BUSY: if (bus.mem_ready) begin
          state <= RESP;
          bus.read_data <= bus.mem_read_data;
          bus.done <= bus.grant;
          bus.mem_func <= '0;
          bus.mem_address <= '0;
          bus.mem_write_data <= '0;
        end
        RESP: begin
          state <= IDLE;
          bus.done <= '0;
          bus.grant <= '0;
`ifdef MEM_ARB_LOCK_EN
          locked <= |(bus.req_lock & bus.grant);
          lock_oh <= bus.grant;
          if (!(|(bus.req_lock & bus.grant))) last <= owner;
`else
          last <= owner;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
